// File: rtl/jk_sync_updown_counter_if.sv
// Control/status bundle for the synchronous JK up/down counter.
// The master drives the count controls; the slave (the counter) returns the count and flags.
interface jk_sync_updown_counter_if #(
   parameter int WIDTH = 4
);
   logic             en;
   logic             up;
   logic             load;
   logic [WIDTH-1:0] load_value;
   logic [WIDTH-1:0] Q;
   logic             tc;
   logic             load_err;

   modport master (
      output en, up, load, load_value,
      input  Q, tc, load_err
   );

   modport slave (
      input  en, up, load, load_value,
      output Q, tc, load_err
   );
endinterface

// File: rtl/jk_sync_updown_counter.sv
// Synchronous mod-N up/down counter of JK toggle cells: 1-clock update latency, tc combinational.
// No backpressure: en/load act at every rising edge; tc carries/borrows into a higher stage's en.
module jk_sync_updown_counter #(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 16
) (
   input logic                       clock,
   input logic                       reset,
   jk_sync_updown_counter_if.slave   bus
);

   localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] t;
   logic [WIDTH-1:0] t_up;
   logic [WIDTH-1:0] t_dn;
   logic             err_nxt;
   logic             load_err_q;
   logic             load_ok;

   function automatic logic jk_next(input logic j, input logic k, input logic qq);
      logic r;
      case ({j, k})
         2'b00:   r = qq;
         2'b01:   r = 1'b0;
         2'b10:   r = 1'b1;
         default: r = ~qq;
      endcase
      return r;
   endfunction

   // Binary carry/borrow chains: bit i toggles when all lower bits are 1 (up) or 0 (down).
   always_comb begin : toggle_chains
      logic cu;
      logic cd;
      t_up = '0;
      t_dn = '0;
      cu   = 1'b1;
      cd   = 1'b1;
      for (int i = 0; i < WIDTH; i++) begin
         t_up[i] = cu;
         t_dn[i] = cd;
         cu      = cu & q[i];
         cd      = cd & ~q[i];
      end
   end

   assign load_ok = ({1'b0, bus.load_value} < MOD_EXT);

   // Every state change, including load and wrap, is expressed as a toggle mask q ^ target.
   always_comb begin
      t       = '0;
      err_nxt = 1'b0;
      if (bus.load) begin
         if (load_ok) begin
            t = q ^ bus.load_value;
         end else begin
            t       = q;
            err_nxt = 1'b1;
         end
      end else if (bus.en) begin
         if (q > MAX_Q) begin
            t = q;
         end else if (bus.up) begin
            t = (q == MAX_Q) ? q : t_up;
         end else begin
            t = (q == '0) ? (q ^ MAX_Q) : t_dn;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         q          <= '0;
         load_err_q <= 1'b0;
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            q[i] <= jk_next(t[i], t[i], q[i]);
         end
         load_err_q <= err_nxt;
      end
   end

   assign bus.Q        = q;
   assign bus.load_err = load_err_q;
   assign bus.tc       = bus.en & ~bus.load &
                         ((bus.up & (q == MAX_Q)) | (~bus.up & (q == '0)));

endmodule

// File: tb/tb_jk_sync_updown_counter.sv
// Bench for jk_sync_updown_counter: mod-16 and mod-10 instances against an arithmetic model,
// plus an 8-bit cascade of two mod-16 stages.
module tb_jk_sync_updown_counter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a;
   logic rst_c;

   jk_sync_updown_counter_if #(.WIDTH(4)) b16 ();
   jk_sync_updown_counter_if #(.WIDTH(4)) b10 ();
   jk_sync_updown_counter_if #(.WIDTH(4)) blo ();
   jk_sync_updown_counter_if #(.WIDTH(4)) bhi ();

   jk_sync_updown_counter #(.WIDTH(4), .MODULUS(16)) u_dut16 (.clock(clk), .reset(rst_a), .bus(b16));
   jk_sync_updown_counter #(.WIDTH(4), .MODULUS(10)) u_dut10 (.clock(clk), .reset(rst_a), .bus(b10));
   jk_sync_updown_counter #(.WIDTH(4), .MODULUS(16)) u_lo    (.clock(clk), .reset(rst_c), .bus(blo));
   jk_sync_updown_counter #(.WIDTH(4), .MODULUS(16)) u_hi    (.clock(clk), .reset(rst_c), .bus(bhi));

   assign bhi.en = blo.tc;

   int n_tests = 0;
   int n_fail  = 0;
   int m16     = 0;
   int m10     = 0;
   bit e16     = 1'b0;
   bit e10     = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int model_q(input int q, input bit r, input bit l, input bit e,
                                  input bit u, input int lv, input int mod);
      if (r)      return 0;
      if (l)      return (lv < mod) ? lv : 0;
      if (!e)     return q;
      if (q >= mod) return 0;
      return u ? (q + 1) % mod : (q + mod - 1) % mod;
   endfunction

   function automatic bit model_err(input bit r, input bit l, input int lv, input int mod);
      return !r && l && (lv >= mod);
   endfunction

   function automatic bit model_tc(input int q, input bit l, input bit e, input bit u, input int mod);
      return e && !l && ((u && q == mod - 1) || (!u && q == 0));
   endfunction

   task automatic step(input bit r, input bit l, input bit e, input bit u, input int lv);
      rst_a = r;
      b16.load = l; b16.en = e; b16.up = u; b16.load_value = 4'(lv);
      b10.load = l; b10.en = e; b10.up = u; b10.load_value = 4'(lv);
      #1;
      check_eq("tc16", 32'(b16.tc), 32'(model_tc(m16, l, e, u, 16)));
      check_eq("tc10", 32'(b10.tc), 32'(model_tc(m10, l, e, u, 10)));
      e16 = model_err(r, l, lv, 16);
      e10 = model_err(r, l, lv, 10);
      m16 = model_q(m16, r, l, e, u, lv, 16);
      m10 = model_q(m10, r, l, e, u, lv, 10);
      @(posedge clk);
      @(negedge clk);
      check_eq("q16",   32'(b16.Q),        32'(m16));
      check_eq("err16", 32'(b16.load_err), 32'(e16));
      check_eq("q10",   32'(b10.Q),        32'(m10));
      check_eq("err10", 32'(b10.load_err), 32'(e10));
   endtask

   initial begin
      rst_a = 1'b1;
      rst_c = 1'b1;
      b16.en = 1'b0; b16.up = 1'b0; b16.load = 1'b0; b16.load_value = '0;
      b10.en = 1'b0; b10.up = 1'b0; b10.load = 1'b0; b10.load_value = '0;
      blo.en = 1'b0; blo.up = 1'b1; blo.load = 1'b0; blo.load_value = '0;
      bhi.up = 1'b1; bhi.load = 1'b0; bhi.load_value = '0;
      @(negedge clk);

      // reset, then 17 up-counts through the wrap
      repeat (2) step(1, 0, 0, 0, 0);
      repeat (17) step(0, 0, 1, 1, 0);
      // down-count through zero
      step(0, 1, 0, 0, 2);
      repeat (4) step(0, 0, 1, 0, 0);
      // out-of-range then in-range load, then up through mod-10 wrap
      step(0, 1, 1, 1, 12);
      step(0, 0, 0, 1, 0);
      step(0, 1, 0, 1, 7);
      repeat (12) step(0, 0, 1, 1, 0);
      // hold, load beats count, reset beats load
      step(0, 1, 0, 1, 5);
      repeat (3) step(0, 0, 0, 1, 0);
      step(0, 1, 1, 1, 3);
      step(1, 1, 1, 1, 9);
      // count to 6, flip direction, reset mid-count, resume
      repeat (6) step(0, 0, 1, 1, 0);
      step(0, 0, 1, 0, 0);
      step(1, 0, 1, 1, 0);
      step(0, 0, 1, 1, 0);
      // boundary loads
      step(0, 1, 0, 0, 9);
      step(0, 1, 0, 0, 10);
      step(0, 1, 0, 0, 15);
      step(0, 0, 1, 1, 0);

      repeat (300) begin
         step(($urandom_range(19) == 0), ($urandom_range(5) == 0), ($urandom_range(3) != 0),
              1'($urandom_range(1)), int'($urandom_range(15)));
      end

      // cascade: lower stage tc enables upper stage
      rst_c  = 1'b0;
      blo.en = 1'b1;
      for (int i = 0; i <= 256; i++) begin
         check_eq("casc", {24'b0, bhi.Q, blo.Q}, 32'(i % 256));
         @(posedge clk);
         @(negedge clk);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
